pwm_multi_ch: RTL

//  - N-channel PWM generator. Each channel runs its own IDLE/LOW/HIGH state machine,

---
 rtl/pwm_multi_ch.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: N-channel PWM, one IDLE/LOW/HIGH FSM per channel, staged L/H lengths applied only at period boundaries.
// Latency: outputs registered, 1 cycle after the sampling edge; no backpressure. Option PWM_PERIOD_IRQ_EN adds period_done_o.
module pwm_multi_ch #(
    parameter int   N_CH       = 4,
    parameter int   WIDTH      = 8,
    parameter bit   IDLE_LEVEL = 1'b0,
    localparam int  CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [N_CH-1:0]   start_i,
    input  logic [N_CH-1:0]   stop_i,
    input  logic              wr_en_i,
    input  logic [CH_W-1:0]   wr_ch_i,
    input  logic              wr_sel_i,
    input  logic [WIDTH-1:0]  wr_data_i,
`ifdef PWM_PERIOD_IRQ_EN
    output logic [N_CH-1:0]   period_done_o,
`endif
    output logic [N_CH-1:0]   pwm_out_o,
    output logic [N_CH-1:0]   busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_e;

    state_e           state_q [N_CH];
    state_e           state_d [N_CH];
    logic [WIDTH-1:0] cnt_q   [N_CH];
    logic [WIDTH-1:0] cnt_d   [N_CH];
    logic [WIDTH-1:0] al_q    [N_CH];
    logic [WIDTH-1:0] al_d    [N_CH];
    logic [WIDTH-1:0] ah_q    [N_CH];
    logic [WIDTH-1:0] ah_d    [N_CH];
    logic [WIDTH-1:0] sl_q    [N_CH];
    logic [WIDTH-1:0] sl_d    [N_CH];
    logic [WIDTH-1:0] sh_q    [N_CH];
    logic [WIDTH-1:0] sh_d    [N_CH];
    logic [N_CH-1:0]  bnd;
    logic [N_CH-1:0]  pwm_q;
    logic [N_CH-1:0]  pwm_d;
    logic [N_CH-1:0]  busy_q;
    logic [N_CH-1:0]  busy_d;
`ifdef PWM_PERIOD_IRQ_EN
    logic [N_CH-1:0]  done_q;
    logic [N_CH-1:0]  done_d;
`endif

    always_comb begin
        bnd    = '0;
        pwm_d  = '0;
        busy_d = '0;
`ifdef PWM_PERIOD_IRQ_EN
        done_d = '0;
`endif
        for (int c = 0; c < N_CH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            al_d[c]    = al_q[c];
            ah_d[c]    = ah_q[c];
            sl_d[c]    = sl_q[c];
            sh_d[c]    = sh_q[c];

            // Out-of-range channel numbers never match any c, so they are dropped.
            if (wr_en_i && (wr_ch_i == CH_W'(c))) begin
                if (wr_sel_i) sh_d[c] = wr_data_i;
                else          sl_d[c] = wr_data_i;
            end

            unique case (state_q[c])
                ST_IDLE: begin
                    if (start_i[c] && !stop_i[c] && ((sl_q[c] != '0) || (sh_q[c] != '0))) begin
                        al_d[c] = sl_q[c];
                        ah_d[c] = sh_q[c];
                        if (sl_q[c] != '0) begin
                            state_d[c] = ST_LOW;
                            cnt_d[c]   = sl_q[c] - WIDTH'(1);
                        end else begin
                            state_d[c] = ST_HIGH;
                            cnt_d[c]   = sh_q[c] - WIDTH'(1);
                        end
                    end
                end
                ST_LOW: begin
                    if (stop_i[c]) begin
                        state_d[c] = ST_IDLE;
                        cnt_d[c]   = '0;
`ifdef PWM_PERIOD_IRQ_EN
                        done_d[c]  = 1'b1;
`endif
                    end else if (cnt_q[c] != '0) begin
                        cnt_d[c] = cnt_q[c] - WIDTH'(1);
                    end else if (ah_q[c] != '0) begin
                        state_d[c] = ST_HIGH;
                        cnt_d[c]   = ah_q[c] - WIDTH'(1);
                    end else begin
                        bnd[c] = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (stop_i[c]) begin
                        state_d[c] = ST_IDLE;
                        cnt_d[c]   = '0;
`ifdef PWM_PERIOD_IRQ_EN
                        done_d[c]  = 1'b1;
`endif
                    end else if (cnt_q[c] != '0) begin
                        cnt_d[c] = cnt_q[c] - WIDTH'(1);
                    end else begin
                        bnd[c] = 1'b1;
                    end
                end
                default: begin
                    state_d[c] = ST_IDLE;
                    cnt_d[c]   = '0;
                end
            endcase

            // Boundary reloads from the pre-write staging values (the _q copies).
            if (bnd[c]) begin
                al_d[c] = sl_q[c];
                ah_d[c] = sh_q[c];
`ifdef PWM_PERIOD_IRQ_EN
                done_d[c] = 1'b1;
`endif
                if (sl_q[c] != '0) begin
                    state_d[c] = ST_LOW;
                    cnt_d[c]   = sl_q[c] - WIDTH'(1);
                end else if (sh_q[c] != '0) begin
                    state_d[c] = ST_HIGH;
                    cnt_d[c]   = sh_q[c] - WIDTH'(1);
                end else begin
                    state_d[c] = ST_IDLE;
                    cnt_d[c]   = '0;
                end
            end

            unique case (state_d[c])
                ST_HIGH: pwm_d[c] = 1'b1;
                ST_LOW:  pwm_d[c] = 1'b0;
                default: pwm_d[c] = IDLE_LEVEL;
            endcase
            busy_d[c] = (state_d[c] != ST_IDLE);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= ST_IDLE;
                cnt_q[c]   <= '0;
                al_q[c]    <= '0;
                ah_q[c]    <= '0;
                sl_q[c]    <= '0;
                sh_q[c]    <= '0;
            end
            pwm_q  <= {N_CH{IDLE_LEVEL}};
            busy_q <= '0;
`ifdef PWM_PERIOD_IRQ_EN
            done_q <= '0;
`endif
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                al_q[c]    <= al_d[c];
                ah_q[c]    <= ah_d[c];
                sl_q[c]    <= sl_d[c];
                sh_q[c]    <= sh_d[c];
            end
            pwm_q  <= pwm_d;
            busy_q <= busy_d;
`ifdef PWM_PERIOD_IRQ_EN
            done_q <= done_d;
`endif
        end
    end

    assign pwm_out_o = pwm_q;
    assign busy_o    = busy_q;
`ifdef PWM_PERIOD_IRQ_EN
    assign period_done_o = done_q;
`endif

endmodule
